rs_ff_pipeline_tail_fifo: RTL and testbench

//  Receiver FIFO at the downstream end of an FF-pipelined stream: data/write cross PIPE_LEVEL register

---
 rtl/rs_ff_pipeline_pkg.sv | 18 +
 rtl/rs_ff_pipeline_tail_fifo_mem.sv | 28 ++
 rtl/rs_ff_pipeline_tail_fifo.sv | 111 +++++++++++
 tb/tb_rs_ff_pipeline_tail_fifo.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rs_ff_pipeline_pkg.sv
// Shared definitions for the FF-pipelined stream receiver: headroom sizing
// and a legality check for the receiver FIFO depth.

`ifndef RS_FF_PIPE_DEPTH_OK
// True when the depth is a power of two and leaves room above the headroom
`define RS_FF_PIPE_DEPTH_OK(d, g) ((((d) & ((d) - 1)) == 0) && ((d) > (g)))
`endif

package rs_ff_pipeline_pkg;

    // Words that can still arrive after full_n drops: full_n needs lvl levels
    // to reach the writer, the writer needs lvl more to stop, plus the word
    // accepted on the cycle full_n was registered.
    function automatic int rs_ff_pipe_grace(input int lvl);
        return 2 * lvl + 1;
    endfunction

endpackage

// File: rtl/rs_ff_pipeline_tail_fifo_mem.sv
// Storage array for the pipeline tail FIFO: one synchronous write port and
// one asynchronous read port so the head word is visible without a read cycle.

module rs_ff_pipeline_tail_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Store the accepted word; contents are deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/rs_ff_pipeline_tail_fifo.sv
// Receiver FIFO at the downstream end of an FF-pipelined stream. Keeps
// GRACE words of headroom below full so every word still in flight after
// full_n drops is absorbed, and presents a first-word-fall-through read side.

import rs_ff_pipeline_pkg::*;

module rs_ff_pipeline_tail_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int PIPE_LEVEL = 2,
    parameter int GRACE      = rs_ff_pipe_grace(PIPE_LEVEL),
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    output logic                  if_full_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    input  logic                  if_read,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow_err
);

    localparam int THRESH = DEPTH - GRACE;
    localparam logic [ADDR_WIDTH:0]   L_FULL    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   L_THRESH  = (ADDR_WIDTH + 1)'(THRESH);
    localparam logic [ADDR_WIDTH:0]   L_CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] L_PTR_ONE = ADDR_WIDTH'(1);

    // Refuse to elaborate with a depth that cannot hold the in-flight words
    if (!(`RS_FF_PIPE_DEPTH_OK(DEPTH, GRACE))) begin : g_bad_depth
        $error("rs_ff_pipeline_tail_fifo: DEPTH must be a power of two greater than GRACE");
    end

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full_n;
    logic                  r_empty_n;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // A pop at full frees its slot on the same edge, so a write is still taken
    assign w_full = (r_count == L_FULL);
    assign w_pop  = if_read & r_empty_n;
    assign w_push = if_write & (~w_full | w_pop);
    assign w_drop = if_write & w_full & ~w_pop;

    // Occupancy after this edge, shared by the counter and the flag registers
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + L_CNT_ONE;
            2'b01:   w_count_next = r_count - L_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Pointers, occupancy, status flags and the sticky overflow indication
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full_n   <= 1'b1;
            r_empty_n  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_count   <= w_count_next;
            r_full_n  <= (w_count_next < L_THRESH);
            r_empty_n <= (w_count_next != '0);
        end
    end

    rs_ff_pipeline_tail_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (if_din),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign if_full_n    = r_full_n;
    assign if_empty_n   = r_empty_n;
    assign if_dout      = r_empty_n ? w_rd_data : '0;
    assign count        = r_count;
    assign overflow_err = r_overflow;

endmodule

// File: tb/tb_rs_ff_pipeline_tail_fifo.sv
// Self-checking bench for the pipeline tail FIFO. A queue-based reference
// model predicts every output after each clock edge.

module tb_rs_ff_pipeline_tail_fifo;

    localparam int DW         = 32;
    localparam int DEPTH      = 16;
    localparam int PIPE_LEVEL = 2;
    localparam int THRESH     = 11;
    localparam int AW         = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] if_din;
    logic          if_write;
    logic          if_full_n;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic          if_read;
    logic [AW:0]   count;
    logic          overflow_err;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [DW-1:0] modelQ[$];
    bit            modelOverflow = 1'b0;
    bit            modelFullN    = 1'b1;

    rs_ff_pipeline_tail_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .PIPE_LEVEL (PIPE_LEVEL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_din       (if_din),
        .if_write     (if_write),
        .if_full_n    (if_full_n),
        .if_dout      (if_dout),
        .if_empty_n   (if_empty_n),
        .if_read      (if_read),
        .count        (count),
        .overflow_err (overflow_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive the next cycle's inputs (called away from the active edge)
    task automatic applyStimulus(input bit rst, input bit wr, input logic [DW-1:0] din, input bit rd);
        reset    = rst;
        if_write = wr;
        if_din   = din;
        if_read  = rd;
    endtask

    // Advance one edge, update the queue model, then compare every output
    task automatic stepCycle();
        bit mPop;
        bit mPush;
        @(posedge clk);
        if (reset) begin
            modelQ.delete();
            modelOverflow = 1'b0;
            modelFullN    = 1'b1;
        end else begin
            mPop  = if_read && (modelQ.size() != 0);
            mPush = if_write && ((modelQ.size() < DEPTH) || mPop);
            if (if_write && !mPush) modelOverflow = 1'b1;
            if (mPop) void'(modelQ.pop_front());
            if (mPush) modelQ.push_back(if_din);
            modelFullN = (modelQ.size() < THRESH);
        end
        #1;
        checkOutput("count", 64'(count), 64'(modelQ.size()));
        checkOutput("empty_n", 64'(if_empty_n), 64'(modelQ.size() != 0));
        checkOutput("full_n", 64'(if_full_n), 64'(modelFullN));
        checkOutput("overflow_err", 64'(overflow_err), 64'(modelOverflow));
        checkOutput("dout", 64'(if_dout), (modelQ.size() != 0) ? 64'(modelQ[0]) : 64'd0);
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic drainAll();
        int guard = 0;
        while (modelQ.size() != 0 && guard < 64) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            stepCycle();
            guard++;
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int       written;
        int       cycles;
        int       maxCount;
        logic [3:0] fullPipe;
        bit       wr;
        bit       rd;

        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        stepCycle();
        checkOutput("reset_count", 64'(count), 64'd0);

        // Test 1: reset held three cycles in the middle of traffic
        $display("[TB] test 1: reset mid-traffic");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, $urandom, i[0]);
            stepCycle();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'($urandom), $urandom, 1'($urandom));
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("t1_count", 64'(count), 64'd0);
        checkOutput("t1_empty_n", 64'(if_empty_n), 64'd0);
        checkOutput("t1_full_n", 64'(if_full_n), 64'd1);
        checkOutput("t1_overflow", 64'(overflow_err), 64'd0);

        // Test 2: threshold crossing, grace absorption and overflow
        $display("[TB] test 2: threshold and overflow");
        for (int i = 0; i < 11; i++) begin
            if (i == 10) checkOutput("t2_full_n_before", 64'(if_full_n), 64'd1);
            applyStimulus(1'b0, 1'b1, DW'(i), 1'b0);
            stepCycle();
        end
        checkOutput("t2_full_n_low", 64'(if_full_n), 64'd0);
        for (int i = 11; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, DW'(i), 1'b0);
            stepCycle();
        end
        checkOutput("t2_count16", 64'(count), 64'd16);
        checkOutput("t2_no_overflow", 64'(overflow_err), 64'd0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0099, 1'b0);
        stepCycle();
        checkOutput("t2_overflow", 64'(overflow_err), 64'd1);
        checkOutput("t2_count_held", 64'(count), 64'd16);
        checkOutput("t2_head", 64'(if_dout), 64'd0);
        drainAll();
        checkOutput("t2_sticky", 64'(overflow_err), 64'd1);
        resetDut();

        // Test 3: first-word fall-through latency
        $display("[TB] test 3: FWFT");
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("t3_empty_n", 64'(if_empty_n), 64'd1);
        checkOutput("t3_dout", 64'(if_dout), 64'hDEAD_BEEF);
        drainAll();

        // Test 4: steady push+pop at the threshold
        $display("[TB] test 4: push+pop at threshold");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, 1'b1, $urandom, 1'b0);
            stepCycle();
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, $urandom, 1'b1);
            stepCycle();
            checkOutput("t4_count", 64'(count), 64'd11);
            checkOutput("t4_full_n", 64'(if_full_n), 64'd0);
        end
        drainAll();

        // Test 5: random traffic with full_n seen through a 4-cycle return path
        $display("[TB] test 5: random wrap traffic");
        written  = 0;
        cycles   = 0;
        maxCount = 0;
        fullPipe = 4'b1111;
        while ((written < 100 || modelQ.size() != 0) && cycles < 3000) begin
            wr = (written < 100) && fullPipe[3] && ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) == 0);
            applyStimulus(1'b0, wr, $urandom, rd);
            stepCycle();
            if (wr) written++;
            if (int'(count) > maxCount) maxCount = int'(count);
            fullPipe = {fullPipe[2:0], if_full_n};
            cycles++;
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("t5_finished", 64'(cycles < 3000), 64'd1);
        checkOutput("t5_written", 64'(written), 64'd100);
        checkOutput("t5_max_count_ok", 64'(maxCount <= DEPTH), 64'd1);
        checkOutput("t5_overflow", 64'(overflow_err), 64'd0);

        // Test 6: read on empty, then push+pop while full
        $display("[TB] test 6: empty read and full push+pop");
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        stepCycle();
        checkOutput("t6_empty_count", 64'(count), 64'd0);
        checkOutput("t6_empty_n", 64'(if_empty_n), 64'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 32'hA000_0000 + DW'(i), 1'b0);
            stepCycle();
        end
        applyStimulus(1'b0, 1'b1, 32'h5555_AAAA, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("t6_full_count", 64'(count), 64'd16);
        checkOutput("t6_full_overflow", 64'(overflow_err), 64'd0);
        checkOutput("t6_full_head", 64'(if_dout), 64'hA000_0001);
        drainAll();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
